// File: rtl/reg_frame_pkg.sv
// Shared types and constants for the register readback frame transmitter.
// frame_len() gives the emitted length (header + payload, padded up to the minimum).
package reg_frame_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HDR     = 2'd1,
      PAYLOAD = 2'd2,
      PAD     = 2'd3
   } state_t;

   localparam int HDR_LEN = 16;

   localparam logic [47:0] DEF_DST_MAC   = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] DEF_SRC_MAC   = 48'h000A_3500_0102;
   localparam logic [15:0] DEF_ETHERTYPE = 16'h88B5;
   localparam int          DEF_MIN_LEN   = 60;

   function automatic int frame_len(input int nregs, input int min_len);
      int raw;
      raw = HDR_LEN + 4 * nregs;
      return (raw < min_len) ? min_len : raw;
   endfunction

endpackage

// File: rtl/reg_frame_tx.sv
// Snapshots the register bank on request and streams it out as one Ethernet frame
// (header, big-endian payload, zero pad) over a byte-wide AXI-stream master.
module reg_frame_tx
   import reg_frame_pkg::*;
#(
   parameter int          NREGS     = 32,
   parameter logic [47:0] DST_MAC   = DEF_DST_MAC,
   parameter logic [47:0] SRC_MAC   = DEF_SRC_MAC,
   parameter logic [15:0] ETHERTYPE = DEF_ETHERTYPE,
   parameter int          MIN_LEN   = DEF_MIN_LEN
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  trigger,
   input  logic [NREGS-1:0][31:0] regs,
   output logic [7:0]            m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   input  logic                  m_axis_tready,
   output logic                  busy,
   output logic [15:0]           seq_num,
   output logic [1:0]            dbg_state
);

   localparam int          LEN       = frame_len(NREGS, MIN_LEN);
   localparam logic [15:0] LAST_IDX  = 16'(LEN - 1);
   localparam logic [15:0] PAY_START = 16'(HDR_LEN);
   localparam logic [15:0] PAY_END   = 16'(HDR_LEN + 4 * NREGS);
   localparam int          IDXW      = (NREGS > 1) ? $clog2(NREGS) : 1;

   state_t                  state;
   logic [15:0]             byte_cnt;
   logic                    pending;
   logic [NREGS-1:0][31:0]  snap;
   logic [15:0]             snap_seq;

   logic [15:0]             next_cnt;
   logic [7:0]              next_byte;
   state_t                  next_state;
   logic [127:0]            hdr_word;
   logic [15:0]             pay_off;
   logic [IDXW-1:0]         reg_idx;
   logic [31:0]             reg_word;

   // Byte selection for the byte that follows the one currently on the bus;
   // it is loaded into tdata on the transfer, so the output stays registered.
   always_comb begin
      next_cnt   = byte_cnt + 16'd1;
      hdr_word   = {DST_MAC, SRC_MAC, ETHERTYPE, snap_seq};
      pay_off    = next_cnt - PAY_START;
      reg_idx    = IDXW'(pay_off >> 2);
      reg_word   = '0;
      next_byte  = 8'h00;
      next_state = PAD;
      if (next_cnt < PAY_START) begin
         next_byte  = 8'(hdr_word >> {4'd15 - next_cnt[3:0], 3'b000});
         next_state = HDR;
      end else if (next_cnt < PAY_END) begin
         reg_word   = snap[reg_idx];
         next_byte  = 8'(reg_word >> {~pay_off[1:0], 3'b000});
         next_state = PAYLOAD;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         byte_cnt      <= '0;
         pending       <= 1'b0;
         snap          <= '0;
         snap_seq      <= '0;
         seq_num       <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pending || trigger) begin
                  snap          <= regs;
                  snap_seq      <= seq_num;
                  pending       <= 1'b0;
                  byte_cnt      <= '0;
                  m_axis_tdata  <= DST_MAC[47:40];
                  m_axis_tvalid <= 1'b1;
                  m_axis_tlast  <= 1'b0;
                  state         <= HDR;
               end
            end
            default: begin
               // A request arriving mid-frame (including on the last byte) queues one frame.
               if (trigger) begin
                  pending <= 1'b1;
               end
               if (m_axis_tvalid && m_axis_tready) begin
                  if (byte_cnt == LAST_IDX) begin
                     m_axis_tvalid <= 1'b0;
                     m_axis_tlast  <= 1'b0;
                     m_axis_tdata  <= '0;
                     seq_num       <= seq_num + 16'd1;
                     state         <= IDLE;
                  end else begin
                     byte_cnt      <= next_cnt;
                     m_axis_tdata  <= next_byte;
                     m_axis_tlast  <= (next_cnt == LAST_IDX);
                     state         <= next_state;
                  end
               end
            end
         endcase
      end
   end

   assign m_axis_tuser = 1'b0;
   assign busy         = (state != IDLE) || pending;
   assign dbg_state    = state;

   a_hold_stable: assert property (@(posedge clk) disable iff (!resetn)
      (m_axis_tvalid && !m_axis_tready) |=>
      (m_axis_tvalid && $stable(m_axis_tdata) && $stable(m_axis_tlast)));

   a_last_pos: assert property (@(posedge clk) disable iff (!resetn)
      m_axis_tlast |-> (m_axis_tvalid && byte_cnt == LAST_IDX));

endmodule

// File: tb/tb_reg_frame_tx.sv
// Directed bench for reg_frame_tx: a default-size instance (32 regs) and a padded
// 4-register instance, each with a byte monitor feeding a frame scoreboard.
module tb_reg_frame_tx;

   localparam int W = 9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic resetn;

   logic             a_trigger, a_tready;
   logic [31:0][31:0] regs_a;
   logic [7:0]       a_tdata;
   logic             a_tvalid, a_tlast, a_tuser, a_busy;
   logic [15:0]      a_seq;
   logic [1:0]       a_state;

   logic             b_trigger, b_tready;
   logic [3:0][31:0] regs_b;
   logic [7:0]       b_tdata;
   logic             b_tvalid, b_tlast, b_tuser, b_busy;
   logic [15:0]      b_seq;
   logic [1:0]       b_state;

   reg_frame_tx dut_a (
      .clk(clk), .resetn(resetn), .trigger(a_trigger), .regs(regs_a),
      .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tlast(a_tlast),
      .m_axis_tuser(a_tuser), .m_axis_tready(a_tready), .busy(a_busy),
      .seq_num(a_seq), .dbg_state(a_state)
   );

   reg_frame_tx #(.NREGS(4)) dut_b (
      .clk(clk), .resetn(resetn), .trigger(b_trigger), .regs(regs_b),
      .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tlast(b_tlast),
      .m_axis_tuser(b_tuser), .m_axis_tready(b_tready), .busy(b_busy),
      .seq_num(b_seq), .dbg_state(b_state)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];
   logic [W-1:0] rx_a[$];
   logic [W-1:0] rx_b[$];
   int           rx_cyc_a[$];
   int           cyc = 0;
   int           tl_a = 0;
   int           tl_b = 0;
   int           vcnt_a = 0;
   logic         hold_v = 1'b0;
   logic [W-1:0] hold_val = '0;
   logic         rand_rdy = 1'b0;
   logic [31:0]  snap_m[32];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] gbyte(input int i);
      if (i < got_q.size()) return got_q[i];
      return 9'h1FF;
   endfunction

   task automatic build_exp(input int nregs, input logic [15:0] seq);
      logic [47:0] dst;
      logic [47:0] src;
      logic [15:0] et;
      logic [7:0]  b[$];
      int          len;
      dst = 48'hFFFF_FFFF_FFFF;
      src = 48'h000A_3500_0102;
      et  = 16'h88B5;
      for (int i = 0; i < 6; i++) b.push_back(dst[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) b.push_back(src[47-8*i -: 8]);
      b.push_back(et[15:8]);
      b.push_back(et[7:0]);
      b.push_back(seq[15:8]);
      b.push_back(seq[7:0]);
      for (int r = 0; r < nregs; r++)
         for (int j = 0; j < 4; j++) b.push_back(snap_m[r][31-8*j -: 8]);
      len = (16 + 4 * nregs < 60) ? 60 : 16 + 4 * nregs;
      while (b.size() < len) b.push_back(8'h00);
      for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), b[i]});
   endtask

   task automatic compare_frame(input string tag);
      check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s_b%0d", tag, i), 32'(gbyte(i)), 32'(exp_q[i]));
      exp_q.delete();
   endtask

   task automatic wait_tlast_a(input int n, input int budget, input string tag);
      int c = 0;
      while (tl_a < n && c < budget) begin
         tick();
         c++;
      end
      check({tag, "_done"}, 32'(tl_a >= n), 32'd1);
   endtask

   task automatic clear_a();
      rx_a.delete();
      rx_cyc_a.delete();
      tl_a = 0;
      vcnt_a = 0;
   endtask

   task automatic take_a();
      got_q = rx_a;
      clear_a();
   endtask

   // Monitors sample at the falling edge; inputs change just after the rising edge.
   always @(negedge clk) begin
      cyc++;
      if (!resetn) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            check("hold_valid", 32'(a_tvalid), 32'd1);
            check("hold_data", 32'({a_tlast, a_tdata}), 32'(hold_val));
         end
         if (a_tvalid) begin
            vcnt_a++;
            check("tuser", 32'(a_tuser), 32'd0);
         end
         if (a_tvalid && a_tready) begin
            rx_a.push_back({a_tlast, a_tdata});
            rx_cyc_a.push_back(cyc);
            if (a_tlast) tl_a++;
         end
         hold_v   = a_tvalid && !a_tready;
         hold_val = {a_tlast, a_tdata};
      end
   end

   always @(negedge clk) begin
      if (resetn && b_tvalid && b_tready) begin
         rx_b.push_back({b_tlast, b_tdata});
         if (b_tlast) tl_b++;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_rdy) a_tready = 1'($urandom_range(0, 1));
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] g;
      int           nl;
      int           c;
      logic         busy_mid;

      resetn    = 1'b0;
      a_trigger = 1'b0;
      a_tready  = 1'b1;
      b_trigger = 1'b0;
      b_tready  = 1'b1;
      regs_a    = '0;
      regs_b    = '0;

      // 1: reset state, then quiet with no trigger
      repeat (5) tick();
      check("t1_tvalid", 32'(a_tvalid), 32'd0);
      check("t1_tlast", 32'(a_tlast), 32'd0);
      check("t1_tdata", 32'(a_tdata), 32'd0);
      check("t1_tuser", 32'(a_tuser), 32'd0);
      check("t1_busy", 32'(a_busy), 32'd0);
      check("t1_seq", 32'(a_seq), 32'd0);
      check("t1_state", 32'(a_state), 32'd0);
      check("t1_b_tvalid", 32'(b_tvalid), 32'd0);
      resetn = 1'b1;
      repeat (20) tick();
      check("t1_quiet", 32'(vcnt_a), 32'd0);
      check("t1_busy_q", 32'(a_busy), 32'd0);

      // 2: single frame, default size, tready held high
      for (int i = 0; i < 32; i++) begin
         regs_a[i] = 32'(32'h0101_0101 * i);
         snap_m[i] = 32'(32'h0101_0101 * i);
      end
      regs_a[1] = 32'h1122_3344;
      snap_m[1] = 32'h1122_3344;
      clear_a();
      check("t2_pre_valid", 32'(a_tvalid), 32'd0);
      a_trigger = 1'b1;
      tick();
      a_trigger = 1'b0;
      check("t2_lat_valid", 32'(a_tvalid), 32'd1);
      check("t2_lat_data", 32'(a_tdata), 32'hFF);
      check("t2_busy", 32'(a_busy), 32'd1);
      wait_tlast_a(1, 400, "t2");
      take_a();
      check("t2_len", 32'(got_q.size()), 32'd144);
      for (int i = 0; i < 6; i++) check($sformatf("t2_dst%0d", i), 32'(gbyte(i)), 32'h0FF);
      check("t2_et_hi", 32'(gbyte(12)), 32'h088);
      check("t2_et_lo", 32'(gbyte(13)), 32'h0B5);
      check("t2_seq_hi", 32'(gbyte(14)), 32'h000);
      check("t2_seq_lo", 32'(gbyte(15)), 32'h000);
      check("t2_r1_b0", 32'(gbyte(20)), 32'h011);
      check("t2_r1_b1", 32'(gbyte(21)), 32'h022);
      check("t2_r1_b2", 32'(gbyte(22)), 32'h033);
      check("t2_r1_b3", 32'(gbyte(23)), 32'h044);
      check("t2_r2_b0", 32'(gbyte(24)), 32'h002);
      nl = 0;
      for (int i = 0; i < got_q.size(); i++) if (got_q[i][8]) nl++;
      check("t2_tlast_count", 32'(nl), 32'd1);
      g = gbyte(143);
      check("t2_tlast_pos", 32'(g[8]), 32'd1);
      build_exp(32, 16'd0);
      compare_frame("t2");
      check("t2_seq_after", 32'(a_seq), 32'd1);
      check("t2_busy_after", 32'(a_busy), 32'd0);

      // 3: random back-pressure, registers rewritten mid-frame
      for (int i = 0; i < 32; i++) begin
         regs_a[i] = 32'(32'h1357_9BDF * (i + 1));
         snap_m[i] = 32'(32'h1357_9BDF * (i + 1));
      end
      clear_a();
      rand_rdy  = 1'b1;
      a_trigger = 1'b1;
      tick();
      a_trigger = 1'b0;
      repeat (20) tick();
      regs_a = ~regs_a;
      wait_tlast_a(1, 3000, "t3");
      rand_rdy = 1'b0;
      a_tready = 1'b1;
      tick();
      take_a();
      build_exp(32, 16'd1);
      compare_frame("t3");
      check("t3_seq_after", 32'(a_seq), 32'd2);

      // 4: four registers, padded to the minimum length
      regs_b[0] = 32'hA0A1_A2A3;
      regs_b[1] = 32'hB0B1_B2B3;
      regs_b[2] = 32'hC0C1_C2C3;
      regs_b[3] = 32'hD0D1_D2D3;
      for (int i = 0; i < 4; i++) snap_m[i] = regs_b[i];
      b_trigger = 1'b1;
      tick();
      b_trigger = 1'b0;
      c = 0;
      while (tl_b < 1 && c < 200) begin
         tick();
         c++;
      end
      check("t4_done", 32'(tl_b >= 1), 32'd1);
      got_q = rx_b;
      rx_b.delete();
      check("t4_len", 32'(got_q.size()), 32'd60);
      check("t4_first_data", 32'(gbyte(16)), 32'h0A0);
      check("t4_last_data", 32'(gbyte(31)), 32'h0D3);
      check("t4_first_pad", 32'(gbyte(32)), 32'h000);
      check("t4_last_pad", 32'(gbyte(59)), 32'h100);
      build_exp(4, 16'd0);
      compare_frame("t4");
      check("t4_seq_after", 32'(b_seq), 32'd1);

      // 5: repeated triggers during a frame queue exactly one more
      resetn = 1'b0;
      repeat (2) tick();
      resetn = 1'b1;
      tick();
      clear_a();
      for (int i = 0; i < 32; i++) begin
         regs_a[i] = 32'hC0DE_0000 + 32'(i);
         snap_m[i] = 32'hC0DE_0000 + 32'(i);
      end
      c = 0;
      busy_mid = 1'b0;
      while (tl_a < 2 && c < 1000) begin
         a_trigger = (c == 0 || c == 10 || c == 30 || c == 60);
         tick();
         if (c == 100) busy_mid = a_busy;
         c++;
      end
      a_trigger = 1'b0;
      check("t5_done", 32'(tl_a >= 2), 32'd1);
      check("t5_busy_mid", 32'(busy_mid), 32'd1);
      check("t5_busy_end", 32'(a_busy), 32'd0);
      if (rx_cyc_a.size() >= 145)
         check("t5_gap", 32'(rx_cyc_a[144] - rx_cyc_a[143]), 32'd2);
      else
         check("t5_gap_len", 32'(rx_cyc_a.size()), 32'd288);
      repeat (30) tick();
      check("t5_no_third", 32'(tl_a), 32'd2);
      take_a();
      check("t5_f1_seq_lo", 32'(gbyte(15)), 32'h000);
      check("t5_f2_seq_lo", 32'(gbyte(159)), 32'h001);
      build_exp(32, 16'd0);
      build_exp(32, 16'd1);
      compare_frame("t5");
      check("t5_seq_after", 32'(a_seq), 32'd2);

      // 6: reset mid-frame aborts, next frame restarts at seq 0
      for (int i = 0; i < 32; i++) begin
         regs_a[i] = 32'h5A00_0000 | 32'(i * 3);
         snap_m[i] = 32'h5A00_0000 | 32'(i * 3);
      end
      a_trigger = 1'b1;
      tick();
      a_trigger = 1'b0;
      c = 0;
      while (rx_a.size() < 70 && c < 200) begin
         tick();
         c++;
      end
      check("t6_reach70", 32'(rx_a.size() >= 70), 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      check("t6_async_valid", 32'(a_tvalid), 32'd0);
      check("t6_async_tlast", 32'(a_tlast), 32'd0);
      check("t6_async_seq", 32'(a_seq), 32'd0);
      check("t6_async_busy", 32'(a_busy), 32'd0);
      repeat (2) tick();
      resetn = 1'b1;
      tick();
      clear_a();
      a_trigger = 1'b1;
      tick();
      a_trigger = 1'b0;
      wait_tlast_a(1, 400, "t6");
      take_a();
      build_exp(32, 16'd0);
      compare_frame("t6");
      check("t6_seq_after", 32'(a_seq), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_frame_tx.md
Name: reg_frame_tx

Overview:
Builds status/readback Ethernet frames from a snapshot of the control register bank and drives them byte-wise onto an AXI-stream master. It sits directly upstream of the tx mac_fifo and replaces frame_gen as the frame source, in the clk (100 MHz) domain. It mirrors frame_rx: registers written by received frames can be read back by the host. The MAC appends the preamble and FCS; this block emits header, payload and padding only.

Parameters:
NREGS, 32, number of 32-bit registers in the snapshot (1..256)
DST_MAC, 48'hFFFF_FFFF_FFFF, destination address placed in bytes 0-5
SRC_MAC, 48'h000A_3500_0102, source address placed in bytes 6-11
ETHERTYPE, 16'h88B5, ethertype placed in bytes 12-13
MIN_LEN, 60, minimum emitted frame length in bytes (excluding FCS)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
trigger  in  1  single-cycle request to send one frame
regs  in  NREGS x 32  register bank to snapshot (packed [NREGS-1:0][31:0])
m_axis_tdata  out  8  frame byte
m_axis_tvalid  out  1  byte valid
m_axis_tlast  out  1  last byte of frame
m_axis_tuser  out  1  error flag, always 0
m_axis_tready  in  1  downstream ready (tx fifo not full)
busy  out  1  frame pending or in progress
seq_num  out  16  sequence number of the next frame to be sent

Behaviour:
- Reset (resetn low, asynchronous): tvalid=0, tlast=0, tdata=0, tuser=0, busy=0, seq_num=0, pending=0, state=IDLE.
- Frame layout: bytes 0-5 DST_MAC (MSB first); bytes 6-11 SRC_MAC; bytes 12-13 ETHERTYPE; bytes 14-15 seq_num (MSB first); bytes 16..16+4*NREGS-1 hold regs[0]..regs[NREGS-1], each big-endian. If 16+4*NREGS < MIN_LEN, zero bytes pad the frame to MIN_LEN. LEN = max(16+4*NREGS, MIN_LEN); with the defaults LEN = 144.
- Byte counter: 16 bits wide, counts 0..LEN-1. A byte transfers when tvalid && tready.
- FSM states:
  - IDLE: if pending or trigger, capture regs and seq_num into the snapshot, clear pending, go to HDR.
  - HDR: bytes 0-15.
  - PAYLOAD: 4*NREGS bytes.
  - PAD: zero bytes, only if padding is needed.
  - After the transfer of byte LEN-1: seq_num increments, state returns to IDLE.
- Latency: trigger sampled high in cycle n (while IDLE) puts byte 0 on the bus with tvalid=1 in cycle n+1.
- Back-to-back: if pending is set when the last byte transfers, byte 0 of the next frame is valid 2 cycles later. tvalid is low for one IDLE cycle between frames.
- AXI-stream rules:
  - Once tvalid is high, tdata, tlast and tvalid hold until tready.
  - tvalid is never deasserted without a transfer.
  - tvalid does not depend combinationally on tready.
  - tlast=1 only on byte LEN-1.
- Snapshot: regs are sampled only at the IDLE->HDR transition. Later changes to regs do not affect the frame in flight.
- Trigger while busy sets pending. Extra triggers while pending is already set are dropped, so at most one frame is queued.
- Trigger in the same cycle as the last-byte transfer sets pending.
- busy = (state != IDLE) || pending.
- seq_num is 16 bits and wraps 0xFFFF -> 0x0000.
- Reset mid-frame aborts immediately and leaves a truncated frame downstream (no tlast). This is accepted because resetn is shared with the fifo/MAC reset.

Decomposition:
- Package reg_frame_pkg:
  - state enum: IDLE, HDR, PAYLOAD, PAD.
  - HDR_LEN = 16.
  - default ETHERTYPE / MAC constants.
  - function frame_len(nregs, min_len).
- No sub-module. Header/payload byte selection is a single registered mux inside the block.

Test Plan:
1. Reset: hold resetn low 5 cycles, release -> all outputs 0, busy=0, seq_num=0; no tvalid for 20 cycles without trigger.
2. Default params, tready=1, regs[i]=32'h0101_0101*i, regs[1]=32'h1122_3344, single trigger:
   - tvalid rises the next cycle.
   - 144 bytes total.
   - bytes 0-5 = FF; bytes 12-13 = 88 B5; bytes 14-15 = 00 00.
   - bytes 20-23 = 11 22 33 44.
   - tlast only on byte 143.
   - seq_num becomes 1.
3. Same as 2 with random tready (50%) and regs changed mid-frame:
   - byte stream identical to the captured snapshot.
   - tdata/tlast stable while tvalid && !tready.
4. NREGS=4, regs = {4'hA..}: 32 data bytes, then 28 zero bytes; tlast on byte 59 (LEN=60).
5. Trigger, then 3 more triggers during the frame:
   - exactly 2 frames, with seq 0 and 1.
   - second frame's byte 0 appears 2 cycles after the first tlast transfer.
   - busy falls after the second tlast.
6. Assert resetn low at byte 70 with tready=1:
   - tvalid=0 asynchronously, seq_num=0.
   - after release, a new trigger yields a complete 144-byte frame with seq 0.
